// File: rtl/muller_c_proj_formal.sv
// Three clocked 2-input Muller C-elements feeding a clocked 3-input C-element,
// with a transition counter on the combined output and a sticky self-check flag.
module muller_c_proj_formal (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] io_in,
  output logic [3:0] io_out,
  output logic [7:0] toggle_cnt,
  output logic       err
);

  logic [2:0] pa, pb;
  logic [2:0] c_q, c_d;
  logic       call_q, call_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       stage_viol, all_viol;

  assign pa = {io_in[4], io_in[2], io_in[0]};
  assign pb = {io_in[5], io_in[3], io_in[1]};

  always_comb begin
    c_d    = (pa & pb) | (c_q & (pa | pb));
    call_d = (&c_q) | (call_q & (|c_q));
    cnt_d  = cnt_q + {7'd0, call_d ^ call_q};
    // A stage may only move when its own inputs agree.
    stage_viol = |((c_d ^ c_q) & (pa ^ pb));
    all_viol   = (call_d ^ call_q) & ~((&c_q) | ~(|c_q));
    err_d      = err_q | stage_viol | all_viol;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q    <= 3'b000;
      call_q <= 1'b0;
      cnt_q  <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      c_q    <= c_d;
      call_q <= call_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign io_out     = {call_q, c_q};
  assign toggle_cnt = cnt_q;
  assign err        = err_q;

`ifdef FORMAL
  logic f_past_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) f_past_q <= 1'b0;
    else        f_past_q <= 1'b1;
  end

  always @(posedge clk) begin
    if (rst_n && f_past_q && $past(rst_n)) begin
      a_stage: assert (c_q == (($past(pa) & $past(pb)) |
                               ($past(c_q) & ($past(pa) | $past(pb)))));
      a_all:   assert (call_q == ((&$past(c_q)) | ($past(call_q) & (|$past(c_q)))));
    end
    if (rst_n) begin
      a_err: assert (err_q == 1'b0);
      c_all_set: cover (call_q);
    end
  end
`endif

endmodule

// File: tb/tb_muller_c_proj_formal.sv
// Scoreboard bench: a behavioural C-element model pushes the expected
// {err, toggle_cnt, io_out} per driven cycle; the value is popped after the edge.
module tb_muller_c_proj_formal;

  logic       clk;
  logic       rst_n;
  logic [5:0] io_in;
  logic [3:0] io_out;
  logic [7:0] toggle_cnt;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  logic [12:0] sb_q[$];
  logic [2:0]  m_c;
  logic        m_call;
  logic [7:0]  m_cnt;

  muller_c_proj_formal dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io_in      (io_in),
    .io_out     (io_out),
    .toggle_cnt (toggle_cnt),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_c    = 3'b000;
    m_call = 1'b0;
    m_cnt  = 8'd0;
    sb_q.delete();
  endtask

  // Drive one cycle of io_in, predict, clock, then compare against the queue head.
  task automatic step(input logic [5:0] v, input string tag);
    logic [2:0]  nc;
    logic        ncall;
    logic [12:0] exp;
    io_in = v;
    for (int k = 0; k < 3; k++) begin
      if (v[2*k] == v[2*k+1]) nc[k] = v[2*k];
      else                    nc[k] = m_c[k];
    end
    if (m_c == 3'b111)      ncall = 1'b1;
    else if (m_c == 3'b000) ncall = 1'b0;
    else                    ncall = m_call;
    if (ncall != m_call) m_cnt = m_cnt + 8'd1;
    m_c    = nc;
    m_call = ncall;
    sb_q.push_back({1'b0, m_cnt, m_call, m_c});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb_q.pop_front();
      chk(tag, {19'd0, err, toggle_cnt, io_out}, {19'd0, exp});
    end
  endtask

  initial begin
    io_in = 6'b000000;
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("rst_io_out", {28'd0, io_out}, 32'd0);
    chk("rst_cnt", {24'd0, toggle_cnt}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", {19'd0, err, toggle_cnt, io_out}, 32'd0);

    // Pair 1 agrees high, pairs 0 and 2 disagree.
    step(6'b101110, "r18");
    chk("r18_out", {28'd0, io_out}, 32'b0010);

    step(6'b111111, "r19a");
    step(6'b111111, "r19b");
    step(6'b101001, "r19c");
    step(6'b101001, "r19d");
    chk("r19_out", {28'd0, io_out}, 32'b1111);
    chk("r19_cnt", {24'd0, toggle_cnt}, 32'd1);

    step(6'b000000, "r20a");
    chk("r20_call_lag", {28'd0, io_out}, 32'b1000);
    step(6'b000000, "r20b");
    chk("r20_out", {28'd0, io_out}, 32'b0000);
    chk("r20_cnt", {24'd0, toggle_cnt}, 32'd2);

    for (int i = 0; i < 40; i++) step(6'($urandom_range(0, 63)), "rand");

    // Fresh reset so the 256-period run lands exactly on a wrap.
    #2 rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
    for (int p = 0; p < 256; p++) begin
      step(6'b111111, "r21_hi");
      step(6'b111111, "r21_hi");
      step(6'b000000, "r21_lo");
      step(6'b000000, "r21_lo");
      if (p == 127) chk("r21_cnt_mid", {24'd0, toggle_cnt}, 32'd0);
      if (p == 126) chk("r21_cnt_254", {24'd0, toggle_cnt}, 32'd254);
    end
    chk("r21_wrap", {24'd0, toggle_cnt}, 32'd0);
    chk("r21_err", {31'd0, err}, 32'd0);

    step(6'b111111, "r22a");
    step(6'b111111, "r22b");
    chk("r22_pre", {28'd0, io_out}, 32'b1111);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("r22_out", {28'd0, io_out}, 32'd0);
    chk("r22_cnt", {24'd0, toggle_cnt}, 32'd0);
    chk("r22_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    chk("r22_held", {19'd0, err, toggle_cnt, io_out}, 32'd0);
    #2 rst_n = 1'b1;
    step(6'b111100, "post_rst_a");
    step(6'b001100, "post_rst_b");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
